// File: rtl/pulse_burst_sequencer_if.sv
// Control/status bundle for the padiwa test-pulse sequencer.
// The master side loads config and issues start/stop; the slave side is the sequencer.
interface pulse_burst_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int NCH   = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_dead;
    logic [15:0]      cfg_count;
    logic [NCH-1:0]   cfg_mask;
    logic             cfg_walk;
    logic [NCH-1:0]   pulse_out;
    logic             spare_out;
    logic             busy;
    logic             done;
    logic [15:0]      pulse_cnt;

    modport master (
        output start, stop, cfg_width, cfg_dead, cfg_count, cfg_mask, cfg_walk,
        input  pulse_out, spare_out, busy, done, pulse_cnt
    );

    modport slave (
        input  start, stop, cfg_width, cfg_dead, cfg_count, cfg_mask, cfg_walk,
        output pulse_out, spare_out, busy, done, pulse_cnt
    );
endinterface

// File: rtl/pulse_burst_sequencer.sv
// Programmable pulse-train generator for the 16 padiwa test-pulse channels:
// fixed width/dead time, finite or continuous count, all-channel or walking-channel mode.
module pulse_burst_sequencer #(
    parameter int CNT_W = 16,
    parameter int NCH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pulse_burst_sequencer_if.slave  bus
);

    localparam int PTR_W = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] sh_width;
    logic [CNT_W-1:0] sh_dead;
    logic [15:0]      sh_count;
    logic [NCH-1:0]   sh_mask;
    logic             sh_walk;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] nxt_ptr;

    logic [NCH-1:0]   pulse_out_p0;
    logic             spare_out_p0;
    logic             busy_p0;
    logic             done_p0;
    logic [15:0]      pulse_cnt_p0;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        at_least_one = (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [PTR_W-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = PTR_W'(i);
        end
    endfunction

    // Index arithmetic wraps naturally because NCH is exactly 2**PTR_W.
    function automatic logic [PTR_W-1:0] next_set(input logic [NCH-1:0] m,
                                                  input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] idx;
        next_set = p;
        for (int i = NCH - 1; i >= 1; i--) begin
            idx = p + PTR_W'(i);
            if (m[idx]) next_set = idx;
        end
    endfunction

    function automatic logic [NCH-1:0] chan_sel(input logic             walk,
                                                input logic [NCH-1:0]   m,
                                                input logic [PTR_W-1:0] p);
        logic [NCH-1:0] one;
        one    = '0;
        one[p] = 1'b1;
        chan_sel = walk ? (one & m) : m;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign nxt_ptr = next_set(sh_mask, ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            sh_width     <= '0;
            sh_dead      <= '0;
            sh_count     <= '0;
            sh_mask      <= '0;
            sh_walk      <= 1'b0;
            ptr          <= '0;
            pulse_out_p0 <= '0;
            spare_out_p0 <= 1'b0;
            busy_p0      <= 1'b0;
            done_p0      <= 1'b0;
            pulse_cnt_p0 <= '0;
        end else begin
            done_p0 <= 1'b0;
            if (state != IDLE && bus.stop) begin
                state        <= IDLE;
                pulse_out_p0 <= '0;
                spare_out_p0 <= 1'b0;
                busy_p0      <= 1'b0;
                done_p0      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            sh_width     <= at_least_one(bus.cfg_width);
                            sh_dead      <= at_least_one(bus.cfg_dead);
                            sh_count     <= bus.cfg_count;
                            sh_mask      <= bus.cfg_mask;
                            sh_walk      <= bus.cfg_walk;
                            ptr          <= lowest_set(bus.cfg_mask);
                            phase_cnt    <= CNT_W'(1);
                            pulse_cnt_p0 <= 16'd1;
                            pulse_out_p0 <= chan_sel(bus.cfg_walk, bus.cfg_mask,
                                                     lowest_set(bus.cfg_mask));
                            spare_out_p0 <= 1'b1;
                            busy_p0      <= 1'b1;
                            state        <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (phase_cnt >= sh_width) begin
                            pulse_out_p0 <= '0;
                            spare_out_p0 <= 1'b0;
                            phase_cnt    <= CNT_W'(1);
                            // Finite runs end straight from the last high phase, no trailing dead time.
                            if (sh_count != 16'd0 && pulse_cnt_p0 == sh_count) begin
                                busy_p0 <= 1'b0;
                                done_p0 <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state   <= LOW;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (phase_cnt >= sh_dead) begin
                            ptr          <= nxt_ptr;
                            pulse_out_p0 <= chan_sel(sh_walk, sh_mask, nxt_ptr);
                            spare_out_p0 <= 1'b1;
                            pulse_cnt_p0 <= sat_inc(pulse_cnt_p0);
                            phase_cnt    <= CNT_W'(1);
                            state        <= HIGH;
                        end else begin
                            phase_cnt <= phase_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pulse_out = pulse_out_p0;
    assign bus.spare_out = spare_out_p0;
    assign bus.busy      = busy_p0;
    assign bus.done      = done_p0;
    assign bus.pulse_cnt = pulse_cnt_p0;

endmodule
